// File: rtl/rob_retire_if.sv
// Retirement-stage bus: ROB head-row fields in, commit/free/clear/flush results out.
// The slave modport is the retire stage; the master modport is the ROB/ARF/front-end side.
interface rob_retire_if #(
    parameter int ROB_DEPTH = 16,
    parameter int PREG_W    = 6,
    parameter int AREG_W    = 5,
    parameter int DATA_W    = 32
);
    localparam int HEAD_W = $clog2(ROB_DEPTH);

    logic              en_flag_i;
    logic              head_valid_i;
    logic              head_comp_i;
    logic              head_exc_i;
    logic [AREG_W-1:0] head_arch_reg_i;
    logic [PREG_W-1:0] head_phy_reg_i;
    logic [PREG_W-1:0] head_old_phy_reg_i;
    logic [DATA_W-1:0] head_result_i;
    logic              flush_ack_i;

    logic [HEAD_W-1:0] rob_head_o;
    logic              rob_clear_o;
    logic [HEAD_W-1:0] rob_clear_idx_o;
    logic              arf_we_o;
    logic [AREG_W-1:0] arf_waddr_o;
    logic [DATA_W-1:0] arf_wdata_o;
    logic              free_we_o;
    logic [PREG_W-1:0] free_reg_o;
    logic              commit_map_we_o;
    logic [PREG_W-1:0] commit_map_preg_o;
    logic              flush_o;
    logic [31:0]       retired_cnt_o;
    logic              en_flag_o;

    modport slave (
        input  en_flag_i, head_valid_i, head_comp_i, head_exc_i,
               head_arch_reg_i, head_phy_reg_i, head_old_phy_reg_i,
               head_result_i, flush_ack_i,
        output rob_head_o, rob_clear_o, rob_clear_idx_o, arf_we_o,
               arf_waddr_o, arf_wdata_o, free_we_o, free_reg_o,
               commit_map_we_o, commit_map_preg_o, flush_o,
               retired_cnt_o, en_flag_o
    );

    modport master (
        output en_flag_i, head_valid_i, head_comp_i, head_exc_i,
               head_arch_reg_i, head_phy_reg_i, head_old_phy_reg_i,
               head_result_i, flush_ack_i,
        input  rob_head_o, rob_clear_o, rob_clear_idx_o, arf_we_o,
               arf_waddr_o, arf_wdata_o, free_we_o, free_reg_o,
               commit_map_we_o, commit_map_preg_o, flush_o,
               retired_cnt_o, en_flag_o
    );
endinterface

// File: rtl/rob_retire.sv
// In-order ROB retirement: commits one completed head row per cycle, or on an
// exception row raises a flush that holds until the front end acknowledges it.
//
//   state | meaning
//   RUN   | retiring completed head rows in order
//   FLUSH | exception seen at head; flush_o held until flush_ack_i
module rob_retire #(
    parameter int ROB_DEPTH = 16,
    parameter int PREG_W    = 6,
    parameter int AREG_W    = 5,
    parameter int DATA_W    = 32
) (
    input logic         clk,
    input logic         rst_n,
    rob_retire_if.slave bus
);
    localparam int HEAD_W = $clog2(ROB_DEPTH);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t state, state_nxt;

    logic              retire_go, exc_go;
    logic [HEAD_W-1:0] head_q, head_d;
    logic              clear_q, clear_d;
    logic [HEAD_W-1:0] clear_idx_q, clear_idx_d;
    logic              arf_we_q, arf_we_d;
    logic [AREG_W-1:0] arf_waddr_q, arf_waddr_d;
    logic [DATA_W-1:0] arf_wdata_q, arf_wdata_d;
    logic              free_we_q, free_we_d;
    logic [PREG_W-1:0] free_reg_q, free_reg_d;
    logic              map_we_q, map_we_d;
    logic [PREG_W-1:0] map_preg_q, map_preg_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              en_q;

    assign retire_go = (state == RUN) && bus.en_flag_i && bus.head_valid_i &&
                       bus.head_comp_i && !bus.head_exc_i;
    assign exc_go    = (state == RUN) && bus.en_flag_i && bus.head_valid_i &&
                       bus.head_comp_i && bus.head_exc_i;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (exc_go) state_nxt = FLUSH;
            FLUSH:   if (bus.flush_ack_i) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Pulses default low; address/data fields hold their last committed value.
    always_comb begin
        head_d      = head_q;
        clear_d     = 1'b0;
        clear_idx_d = clear_idx_q;
        arf_we_d    = 1'b0;
        arf_waddr_d = arf_waddr_q;
        arf_wdata_d = arf_wdata_q;
        free_we_d   = 1'b0;
        free_reg_d  = free_reg_q;
        map_we_d    = 1'b0;
        map_preg_d  = map_preg_q;
        cnt_d       = cnt_q;
        if (retire_go) begin
            head_d      = head_q + HEAD_W'(1);
            clear_d     = 1'b1;
            clear_idx_d = head_q;
            arf_we_d    = (bus.head_arch_reg_i != '0);
            arf_waddr_d = bus.head_arch_reg_i;
            arf_wdata_d = bus.head_result_i;
            map_we_d    = (bus.head_arch_reg_i != '0);
            map_preg_d  = bus.head_phy_reg_i;
            free_we_d   = (bus.head_old_phy_reg_i != '0);
            free_reg_d  = bus.head_old_phy_reg_i;
            cnt_d       = cnt_q + 32'd1;
        end else if (state == FLUSH && bus.flush_ack_i) begin
            head_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            clear_q     <= 1'b0;
            clear_idx_q <= '0;
            arf_we_q    <= 1'b0;
            arf_waddr_q <= '0;
            arf_wdata_q <= '0;
            free_we_q   <= 1'b0;
            free_reg_q  <= '0;
            map_we_q    <= 1'b0;
            map_preg_q  <= '0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            head_q      <= head_d;
            clear_q     <= clear_d;
            clear_idx_q <= clear_idx_d;
            arf_we_q    <= arf_we_d;
            arf_waddr_q <= arf_waddr_d;
            arf_wdata_q <= arf_wdata_d;
            free_we_q   <= free_we_d;
            free_reg_q  <= free_reg_d;
            map_we_q    <= map_we_d;
            map_preg_q  <= map_preg_d;
            cnt_q       <= cnt_d;
            en_q        <= bus.en_flag_i;
        end
    end

    assign bus.rob_head_o        = head_q;
    assign bus.rob_clear_o       = clear_q;
    assign bus.rob_clear_idx_o   = clear_idx_q;
    assign bus.arf_we_o          = arf_we_q;
    assign bus.arf_waddr_o       = arf_waddr_q;
    assign bus.arf_wdata_o       = arf_wdata_q;
    assign bus.free_we_o         = free_we_q;
    assign bus.free_reg_o        = free_reg_q;
    assign bus.commit_map_we_o   = map_we_q;
    assign bus.commit_map_preg_o = map_preg_q;
    assign bus.flush_o           = (state == FLUSH);
    assign bus.retired_cnt_o     = cnt_q;
    assign bus.en_flag_o         = en_q;
endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: a reference model pushes the expected commit per
// clock into a scoreboard queue, popped and compared just after each edge.
module tb_rob_retire;
    logic clk;
    logic rst_n;

    rob_retire_if bus ();

    rob_retire dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        free_we;
        logic [5:0]  freg;
        logic        map_we;
        logic [5:0]  preg;
        logic        clr;
        logic [3:0]  idx;
    } exp_t;

    exp_t sbq[$];

    int   total = 0;
    int   bad   = 0;
    int   exp_head = 0;
    int   exp_cnt  = 0;
    logic exp_flush = 1'b0;
    logic exp_en    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_row(input logic v, input logic c, input logic e, input int arch,
                           input int phy, input int old, input int res);
        bus.head_valid_i       = v;
        bus.head_comp_i        = c;
        bus.head_exc_i         = e;
        bus.head_arch_reg_i    = 5'(arch);
        bus.head_phy_reg_i     = 6'(phy);
        bus.head_old_phy_reg_i = 6'(old);
        bus.head_result_i      = 32'(res);
    endtask

    // Model the edge about to happen from the currently driven inputs, then check.
    task automatic tick();
        exp_t e;
        e = '{default: '0};
        if (!rst_n) begin
            exp_head = 0; exp_cnt = 0; exp_flush = 1'b0; exp_en = 1'b0;
        end else begin
            exp_en = bus.en_flag_i;
            if (!exp_flush) begin
                if (bus.en_flag_i && bus.head_valid_i && bus.head_comp_i) begin
                    if (bus.head_exc_i) begin
                        exp_flush = 1'b1;
                    end else begin
                        e.arf_we  = (bus.head_arch_reg_i != 0);
                        e.waddr   = bus.head_arch_reg_i;
                        e.wdata   = bus.head_result_i;
                        e.map_we  = (bus.head_arch_reg_i != 0);
                        e.preg    = bus.head_phy_reg_i;
                        e.free_we = (bus.head_old_phy_reg_i != 0);
                        e.freg    = bus.head_old_phy_reg_i;
                        e.clr     = 1'b1;
                        e.idx     = 4'(exp_head);
                        exp_head  = (exp_head + 1) % 16;
                        exp_cnt++;
                    end
                end
            end else if (bus.flush_ack_i) begin
                exp_flush = 1'b0;
                exp_head  = 0;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("arf_we", 64'(bus.arf_we_o), 64'(e.arf_we));
        check("map_we", 64'(bus.commit_map_we_o), 64'(e.map_we));
        check("free_we", 64'(bus.free_we_o), 64'(e.free_we));
        check("clear", 64'(bus.rob_clear_o), 64'(e.clr));
        if (e.arf_we) begin
            check("arf_waddr", 64'(bus.arf_waddr_o), 64'(e.waddr));
            check("arf_wdata", 64'(bus.arf_wdata_o), 64'(e.wdata));
        end
        if (e.map_we) check("map_preg", 64'(bus.commit_map_preg_o), 64'(e.preg));
        if (e.free_we) check("free_reg", 64'(bus.free_reg_o), 64'(e.freg));
        if (e.clr) check("clear_idx", 64'(bus.rob_clear_idx_o), 64'(e.idx));
        check("head", 64'(bus.rob_head_o), 64'(exp_head));
        check("retired_cnt", 64'(bus.retired_cnt_o), 64'(exp_cnt));
        check("flush", 64'(bus.flush_o), 64'(exp_flush));
        check("en_flag", 64'(bus.en_flag_o), 64'(exp_en));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.en_flag_i   = 1'b1;
        bus.flush_ack_i = 1'b0;
        set_row(0, 0, 0, 0, 0, 0, 0);
        #1;
        tick();
        tick();
        check("rst_arf_waddr", 64'(bus.arf_waddr_o), 64'd0);
        check("rst_arf_wdata", 64'(bus.arf_wdata_o), 64'd0);
        check("rst_free_reg", 64'(bus.free_reg_o), 64'd0);
        check("rst_map_preg", 64'(bus.commit_map_preg_o), 64'd0);
        check("rst_clear_idx", 64'(bus.rob_clear_idx_o), 64'd0);

        // Three back-to-back completed rows.
        rst_n = 1'b1;
        set_row(1, 1, 0, 3, 10, 7, 32'h11); tick();
        set_row(1, 1, 0, 4, 11, 8, 32'h22); tick();
        set_row(1, 1, 0, 5, 12, 9, 32'h33); tick();
        set_row(0, 0, 0, 0, 0, 0, 0);       tick();
        check("head_after_three", 64'(bus.rob_head_o), 64'd3);
        check("cnt_after_three", 64'(bus.retired_cnt_o), 64'd3);

        // Valid but incomplete for five cycles, then completes.
        set_row(1, 0, 0, 6, 13, 14, 32'h44);
        for (int i = 0; i < 5; i++) tick();
        set_row(1, 1, 0, 6, 13, 14, 32'h44); tick();
        set_row(0, 0, 0, 0, 0, 0, 0);       tick();

        // Arch reg 0 with old preg 0: only the clear pulse and the count.
        set_row(1, 1, 0, 0, 15, 0, 32'h55); tick();

        // Stage disabled stalls an eligible row.
        bus.en_flag_i = 1'b0;
        set_row(1, 1, 0, 7, 16, 17, 32'h66);
        tick(); tick();
        bus.en_flag_i = 1'b1;
        tick();

        // Ack while running is ignored.
        set_row(0, 0, 0, 0, 0, 0, 0);
        bus.flush_ack_i = 1'b1; tick();
        bus.flush_ack_i = 1'b0;
        check("head_before_exc", 64'(bus.rob_head_o), 64'd6);

        // Exception at head 6, ack after four cycles of waiting.
        set_row(1, 1, 1, 8, 18, 19, 32'h77); tick();
        for (int i = 0; i < 4; i++) tick();
        bus.flush_ack_i = 1'b1; tick();
        bus.flush_ack_i = 1'b0;
        set_row(1, 1, 0, 9, 20, 21, 32'h88); tick();

        // Retire through head 15 and wrap to 0.
        for (int i = 0; i < 15; i++) begin
            set_row(1, 1, 0, 1 + i, 22 + i, 40 + i, 32'h1000 + i);
            tick();
        end
        set_row(0, 0, 0, 0, 0, 0, 0); tick();
        check("head_wrap", 64'(bus.rob_head_o), 64'd0);

        // Reset in the middle of a flush.
        set_row(1, 1, 1, 2, 3, 4, 32'h99); tick();
        tick();
        bus.en_flag_i = 1'b0;
        rst_n = 1'b0; tick();
        check("rst_flush_drop", 64'(bus.flush_o), 64'd0);
        rst_n = 1'b1;
        set_row(0, 0, 0, 0, 0, 0, 0);
        bus.en_flag_i = 1'b1; tick();
        bus.en_flag_i = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
